pkt_rd_ctrl: RTL and testbench
==============================

// Module: pkt_rd_ctrl
// PURPOSE
//   Avalon-MM burst-read master that fetches one captured packet from memory, range [pkt_begin, pkt_end),
//   and pushes it word by word into a downstream FIFO. It is the read-back counterpart of the
//   capture-path write controller and feeds the export/readout path. One burst is outstanding at a time.
//   A burst is issued only when the FIFO can absorb the whole burst.
// PARAMETERS
//   MAX_BURST   16   max beats per Avalon burst (1..65535)
//   DATA_W      32   word width; byte stride per beat = 4
// PORTS
//   clk            in   1   clock
//   reset          in   1   synchronous, active-low reset
//   rd_ctrl        in   1   start pulse; sampled only in IDLE
//   pkt_begin      in   32  byte address of first word, latched on start
//   pkt_end        in   32  byte address one past last word, latched on start
//   rd_ctrl_rdy    out  1   1-cycle pulse when packet fully delivered
//   busy           out  1   high in any state other than IDLE
//   fifo_free      in   16  free word slots in downstream FIFO
//   fifo_wr        out  1   FIFO write strobe
//   fifo_data      out  32  FIFO write data
//   address        out  32  Avalon byte address of current burst
//   read           out  1   Avalon read request
//   burstcount     out  16  beats in current burst
//   waitrequest    in   1   Avalon stall
//   readdata       in   32  Avalon read data
//   readdatavalid  in   1   Avalon beat valid
// BEHAVIOUR
//   Reset (reset==0 at posedge): state=IDLE; all outputs 0 at the next edge. Reset mid-burst abandons the
//     transfer; beats arriving after reset are dropped (IDLE ignores readdatavalid).
//   Length: words = (pkt_end - pkt_begin) >> 2 if pkt_end > pkt_begin, else 0; low 2 address bits ignored.
//     Words are tracked in a 32-bit remaining counter.
//   FSM  IDLE -> (rd_ctrl) latch addr/words; words==0 ? DONE : ARB
//        ARB  : blen = min(MAX_BURST, remaining); if fifo_free >= blen -> REQ, else stay in ARB.
//        REQ  : drive read=1, address, burstcount=blen, all held stable while waitrequest=1.
//               On the cycle with waitrequest=0: read drops next cycle; address += blen*4;
//               remaining -= blen; -> DATA.
//        DATA : each readdatavalid beat: fifo_data<=readdata, fifo_wr<=1 (registered, 1-cycle latency);
//               beat counter++. On the last beat (count==blen): remaining==0 ? DONE : ARB.
//        DONE : rd_ctrl_rdy=1 for exactly one cycle -> IDLE.
//   rd_ctrl while busy is ignored. readdatavalid outside DATA is ignored.
//   fifo_wr never asserts without a matching readdatavalid. Total fifo_wr pulses == words.
//   blen is computed from the latched remaining count. The final burst may be shorter than MAX_BURST.
//   Address wraps modulo 2^32 with no error.
//   Minimum turnaround: rd_ctrl_rdy follows the last fifo_wr by 1 cycle; busy drops on the cycle after DONE.
// TESTING
//   begin=0x1000,end=0x1040 (16 words), fifo_free=64, waitreq=0 -> one burst addr 0x1000 bc=16;
//     16 fifo_wr with data order preserved; rd_ctrl_rdy pulse.
//   begin=0x2000,end=0x2094 (37 words), MAX_BURST=16 -> bursts 0x2000/16, 0x2040/16, 0x2080/5;
//     37 fifo_wr total.
//   fifo_free=8, 16-word packet -> read stays low in ARB; raise fifo_free to 16 -> burst issued next cycle.
//   waitrequest held 5 cycles in REQ -> address, burstcount and read stable all 5 cycles; a single accept.
//   end==begin and end<begin -> no read; rd_ctrl_rdy 2 cycles after rd_ctrl; no fifo_wr.
//   reset low after 3 of 16 beats -> outputs 0, IDLE; residual beats produce no fifo_wr;
//     a new start then runs cleanly.

Source files
------------

// File: rtl/pkt_rd_ctrl_if.sv
// Avalon-MM burst-read bus between the packet read controller and memory.
interface pkt_rd_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       address;
    logic              read;
    logic [15:0]       burstcount;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, burstcount,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/pkt_rd_ctrl.sv
// Burst-read master: fetches [pkt_begin, pkt_end) from memory into a FIFO,
// one outstanding burst at a time, only when the FIFO can take the whole burst.
module pkt_rd_ctrl #(
    parameter int MAX_BURST = 16,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_ctrl,
    input  logic [31:0]       pkt_begin,
    input  logic [31:0]       pkt_end,
    output logic              rd_ctrl_rdy,
    output logic              busy,
    input  logic [15:0]       fifo_free,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_data,
    pkt_rd_ctrl_if.master     av
);
    typedef enum logic [2:0] {
        IDLE,
        ARB,
        REQ,
        DATA,
        DONE
    } state_t;

    localparam logic [15:0] MB16 = 16'(MAX_BURST);

    state_t      state, state_n;
    logic [31:0] rem;
    logic [31:0] addr_q;
    logic [15:0] blen_q;
    logic [15:0] beat_cnt;
    logic        read_q;
    logic        rdy_q;
    logic [31:0] words;
    logic [15:0] blen;

    logic load, issue, accept, beat, finish;

    assign words = (pkt_end > pkt_begin) ? ((pkt_end - pkt_begin) >> 2) : '0;
    assign blen  = (rem > {16'd0, MB16}) ? MB16 : rem[15:0];

    assign av.address    = addr_q;
    assign av.read       = read_q;
    assign av.burstcount = blen_q;
    assign rd_ctrl_rdy   = rdy_q;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        issue   = 1'b0;
        accept  = 1'b0;
        beat    = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_ctrl) begin
                    load    = 1'b1;
                    state_n = (words == '0) ? DONE : ARB;
                end
            end
            ARB: begin
                if (fifo_free >= blen) begin
                    issue   = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (!av.waitrequest) begin
                    accept  = 1'b1;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (av.readdatavalid) begin
                    beat = 1'b1;
                    if (beat_cnt + 16'd1 == blen_q)
                        state_n = (rem == '0) ? DONE : ARB;
                end
            end
            DONE: begin
                finish  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // rem is decremented at accept, so DATA's last beat sees what is left after this burst
    always_ff @(posedge clk) begin
        if (!reset) begin
            rem       <= '0;
            addr_q    <= '0;
            blen_q    <= '0;
            beat_cnt  <= '0;
            read_q    <= 1'b0;
            rdy_q     <= 1'b0;
            fifo_wr   <= 1'b0;
            fifo_data <= '0;
        end else begin
            fifo_wr <= 1'b0;
            rdy_q   <= finish;
            if (load) begin
                addr_q <= {pkt_begin[31:2], 2'b00};
                rem    <= words;
            end
            if (issue) begin
                read_q <= 1'b1;
                blen_q <= blen;
            end
            if (accept) begin
                read_q   <= 1'b0;
                addr_q   <= addr_q + {14'd0, blen_q, 2'b00};
                rem      <= rem - {16'd0, blen_q};
                beat_cnt <= '0;
            end
            if (beat) begin
                fifo_wr   <= 1'b1;
                fifo_data <= av.readdata;
                beat_cnt  <= beat_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_pkt_rd_ctrl.sv
// Directed bench for pkt_rd_ctrl: vector table plus stall, backpressure
// and mid-burst reset sequences against a simple burst memory model.
module tb_pkt_rd_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        rd_ctrl;
    logic [31:0] pkt_begin, pkt_end;
    logic        rd_ctrl_rdy, busy;
    logic [15:0] fifo_free;
    logic        fifo_wr;
    logic [31:0] fifo_data;

    pkt_rd_ctrl_if #(.DATA_W(32)) bus ();

    pkt_rd_ctrl #(.MAX_BURST(16), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_ctrl     (rd_ctrl),
        .pkt_begin   (pkt_begin),
        .pkt_end     (pkt_end),
        .rd_ctrl_rdy (rd_ctrl_rdy),
        .busy        (busy),
        .fifo_free   (fifo_free),
        .fifo_wr     (fifo_wr),
        .fifo_data   (fifo_data),
        .av          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    // memory slave model
    int          wait_cfg = 0;
    int          stall_cnt = 0;
    int          pend_beats = 0;
    logic [31:0] pend_addr;
    logic [31:0] a0;
    logic [15:0] b0;
    logic [31:0] acc_addr[$];
    logic [15:0] acc_bc[$];

    initial begin
        bus.waitrequest   = 1'b0;
        bus.readdatavalid = 1'b0;
        bus.readdata      = '0;
    end

    always @(negedge clk) begin
        if (pend_beats > 0) begin
            bus.readdatavalid = 1'b1;
            bus.readdata      = word_of(pend_addr);
            pend_addr         = pend_addr + 32'd4;
            pend_beats--;
        end else begin
            bus.readdatavalid = 1'b0;
        end
        if (bus.read) begin
            if (stall_cnt == 0) begin
                a0 = bus.address;
                b0 = bus.burstcount;
            end else begin
                chk("stall_addr", bus.address, a0);
                chk("stall_bc", {16'd0, bus.burstcount}, {16'd0, b0});
            end
            if (stall_cnt < wait_cfg) begin
                bus.waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                bus.waitrequest = 1'b0;
                acc_addr.push_back(bus.address);
                acc_bc.push_back(bus.burstcount);
                pend_addr  = bus.address;
                pend_beats = int'(bus.burstcount);
                stall_cnt  = 0;
            end
        end else begin
            if (stall_cnt != 0) chk("read_drop", 32'd0, 32'd1);
            bus.waitrequest = 1'b0;
            stall_cnt       = 0;
        end
    end

    // FIFO-side monitor
    int          ncyc = 0;
    int          last_wr = 0;
    int          wr_cnt = 0;
    logic [31:0] exp_addr;

    always @(negedge clk) begin
        ncyc++;
        if (fifo_wr) begin
            chk("fifo_data", fifo_data, word_of(exp_addr));
            exp_addr = exp_addr + 32'd4;
            wr_cnt++;
            last_wr = ncyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_pkt(input logic [31:0] b, input logic [31:0] e);
        pkt_begin = b;
        pkt_end   = e;
        exp_addr  = {b[31:2], 2'b00};
        wr_cnt    = 0;
        acc_addr.delete();
        acc_bc.delete();
        rd_ctrl = 1'b1;
        tick();
        rd_ctrl = 1'b0;
        chk("busy_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int nwords, output int lat);
        lat = 0;
        while (!rd_ctrl_rdy && lat < 3000) begin
            tick();
            lat++;
        end
        if (!rd_ctrl_rdy) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("busy_at_rdy", {31'd0, busy}, 32'd0);
            if (nwords > 0) chk("rdy_after_wr", 32'(ncyc - last_wr), 32'd1);
            tick();
            chk("rdy_pulse", {31'd0, rd_ctrl_rdy}, 32'd0);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_read"}, {31'd0, bus.read}, 32'd0);
        chk({tag, "_wr"}, {31'd0, fifo_wr}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, rd_ctrl_rdy}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_addr"}, bus.address, 32'd0);
        chk({tag, "_bc"}, {16'd0, bus.burstcount}, 32'd0);
        chk({tag, "_data"}, fifo_data, 32'd0);
    endtask

    typedef struct {
        logic [31:0] beg;
        logic [31:0] fin;
        logic [15:0] free;
        int          wt;
        int          words;
        int          bursts;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int lat;
        int n;
        vecs[0] = '{32'h0000_1000, 32'h0000_1040, 16'd64, 0, 16, 1};
        vecs[1] = '{32'h0000_2000, 32'h0000_2094, 16'd64, 0, 37, 3};
        vecs[2] = '{32'h0000_3000, 32'h0000_3000, 16'd64, 0, 0, 0};
        vecs[3] = '{32'h0000_4000, 32'h0000_3F00, 16'd64, 0, 0, 0};
        vecs[4] = '{32'h0000_5003, 32'h0000_5010, 16'd64, 0, 3, 1};
        vecs[5] = '{32'hFFFF_FFC0, 32'hFFFF_FFFF, 16'd64, 0, 15, 1};
        vecs[6] = '{32'h0000_6000, 32'h0000_6050, 16'd64, 3, 20, 2};
        vecs[7] = '{32'h0000_7000, 32'h0000_7040, 16'd16, 5, 16, 1};
        vecs[8] = '{32'hFFFF_FFF0, 32'h0000_0010, 16'd64, 0, 0, 0};

        reset     = 1'b0;
        rd_ctrl   = 1'b0;
        pkt_begin = '0;
        pkt_end   = '0;
        fifo_free = 16'd64;
        exp_addr  = '0;
        repeat (3) tick();
        chk_idle_zero("reset");
        reset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            int          left;
            logic [31:0] base;
            fifo_free = vecs[i].free;
            wait_cfg  = vecs[i].wt;
            start_pkt(vecs[i].beg, vecs[i].fin);
            wait_done(vecs[i].words, lat);
            if (vecs[i].words == 0) chk($sformatf("v%0d_lat", i), 32'(lat), 32'd1);
            tick();
            chk($sformatf("v%0d_words", i), 32'(wr_cnt), 32'(vecs[i].words));
            chk($sformatf("v%0d_bursts", i), 32'(acc_addr.size()), 32'(vecs[i].bursts));
            base = {vecs[i].beg[31:2], 2'b00};
            left = vecs[i].words;
            for (int j = 0; j < acc_addr.size(); j++) begin
                chk($sformatf("v%0d_b%0d_addr", i, j), acc_addr[j], base + 32'(64 * j));
                chk($sformatf("v%0d_b%0d_bc", i, j), {16'd0, acc_bc[j]},
                    32'((left > 16) ? 16 : left));
                left -= 16;
            end
        end
        wait_cfg = 0;

        // FIFO backpressure: 8 and 15 free hold the 16-beat burst, 16 releases it
        fifo_free = 16'd8;
        start_pkt(32'h0000_A000, 32'h0000_A040);
        repeat (4) begin
            chk("arb_hold8", {31'd0, bus.read}, 32'd0);
            tick();
        end
        fifo_free = 16'd15;
        repeat (3) begin
            tick();
            chk("arb_hold15", {31'd0, bus.read}, 32'd0);
        end
        chk("arb_busy", {31'd0, busy}, 32'd1);
        fifo_free = 16'd16;
        tick();
        chk("arb_issue", {31'd0, bus.read}, 32'd1);
        chk("arb_addr", bus.address, 32'h0000_A000);
        chk("arb_bc", {16'd0, bus.burstcount}, 32'd16);
        wait_done(16, lat);
        chk("arb_words", 32'(wr_cnt), 32'd16);
        fifo_free = 16'd64;

        // reset after three beats, then residual beats must be dropped
        start_pkt(32'h0000_B000, 32'h0000_B040);
        n = 0;
        while (wr_cnt < 3 && n < 100) begin
            tick();
            n++;
        end
        chk("rst_three", 32'(wr_cnt), 32'd3);
        reset = 1'b0;
        tick();
        chk_idle_zero("midrst");
        reset = 1'b1;
        n = 0;
        while (pend_beats > 0 && n < 100) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("residual_wr", 32'(wr_cnt), 32'd3);
        chk("residual_busy", {31'd0, busy}, 32'd0);
        start_pkt(32'h0000_C000, 32'h0000_C040);
        wait_done(16, lat);
        tick();
        chk("post_rst_words", 32'(wr_cnt), 32'd16);
        chk("post_rst_bursts", 32'(acc_addr.size()), 32'd1);
        if (acc_addr.size() == 1)
            chk("post_rst_addr", acc_addr[0], 32'h0000_C000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
